// File: rtl/aclk_tickgen.sv
// -----------------------------------------------------------------------------
// aclk_tickgen
// Time-base generator for the alarm-clock datapath. A prescaler divides clk
// into second periods. Second periods are counted into minutes and minutes
// into hours. Each boundary produces a single-cycle strobe. Fast mode turns
// every second period into a minute strobe, so the display and alarm logic
// can be exercised quickly.
//
// Ports
//   clk         in   1   clock; all state changes on posedge
//   reset       in   1   asynchronous, active-high clear of all state
//   reset_count in   1   synchronous clear of counters and strobes
//   enable      in   1   1 = count, 0 = hold counters (strobes drop to 0)
//   fast_watch  in   1   1 = minute strobe on every second period
//   one_second  out  1   strobe per second period (normal mode only)
//   one_minute  out  1   strobe per minute
//   one_hour    out  1   strobe per MINS_PER_HOUR minutes
//   sec_count   out  SW  current second index, 0..SECS_PER_MIN-1
//   min_count   out  MW  current minute index, 0..MINS_PER_HOUR-1
// -----------------------------------------------------------------------------
module aclk_tickgen #(
    parameter int TICKS_PER_SEC = 256,
    parameter int SECS_PER_MIN  = 60,
    parameter int MINS_PER_HOUR = 60,
    localparam int TW = $clog2(TICKS_PER_SEC),
    localparam int SW = $clog2(SECS_PER_MIN),
    localparam int MW = $clog2(MINS_PER_HOUR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reset_count,
    input  logic          enable,
    input  logic          fast_watch,
    output logic          one_second,
    output logic          one_minute,
    output logic          one_hour,
    output logic [SW-1:0] sec_count,
    output logic [MW-1:0] min_count
);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(SECS_PER_MIN - 1);
    localparam logic [MW-1:0] MIN_LAST  = MW'(MINS_PER_HOUR - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] sec_q,  sec_d;
    logic [MW-1:0] min_q,  min_d;
    logic          one_second_q, one_second_d;
    logic          one_minute_q, one_minute_d;
    logic          one_hour_q,   one_hour_d;
    logic          sec_wrap;
    logic          min_adv;

    // The prescaler reaches its last tick; the wrap happens on this edge.
    assign sec_wrap = (tick_q == TICK_LAST);

    always_comb begin
        tick_d       = tick_q;
        sec_d        = sec_q;
        min_d        = min_q;
        one_second_d = 1'b0;
        one_minute_d = 1'b0;
        one_hour_d   = 1'b0;
        min_adv      = 1'b0;

        if (reset_count) begin
            tick_d = '0;
            sec_d  = '0;
            min_d  = '0;
        end else if (enable) begin
            tick_d = sec_wrap ? '0 : tick_q + 1'b1;

            if (fast_watch) begin
                // Fast mode keeps sec_count pinned at 0. A return to normal
                // mode therefore starts a fresh minute.
                sec_d = '0;
                if (sec_wrap) begin
                    one_minute_d = 1'b1;
                    min_adv      = 1'b1;
                end
            end else if (sec_wrap) begin
                one_second_d = 1'b1;
                if (sec_q == SEC_LAST) begin
                    sec_d        = '0;
                    one_minute_d = 1'b1;
                    min_adv      = 1'b1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end

            if (min_adv) begin
                if (min_q == MIN_LAST) begin
                    min_d      = '0;
                    one_hour_d = 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end
        end
        // When enable is 0, the counters hold and the strobes stay at their
        // 0 default. This preserves the phase across the pause.
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q       <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            one_second_q <= 1'b0;
            one_minute_q <= 1'b0;
            one_hour_q   <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            one_second_q <= one_second_d;
            one_minute_q <= one_minute_d;
            one_hour_q   <= one_hour_d;
        end
    end

    assign one_second = one_second_q;
    assign one_minute = one_minute_q;
    assign one_hour   = one_hour_q;
    assign sec_count  = sec_q;
    assign min_count  = min_q;

endmodule
